// File: rtl/sync_fifo_flex_if.sv
// Handshake bundle for sync_fifo_flex: write side, read side, status and occupancy.
// Error-flag signals exist only when FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_flex_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             full;
    logic             almost_full;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
`ifdef FIFO_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, data_in, rd_en,
        input  full, almost_full, data_out, empty, almost_empty, count,
               overflow, underflow
    );
    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output full, almost_full, data_out, empty, almost_empty, count,
               overflow, underflow
    );
`else
    modport master (
        output flush, wr_en, data_in, rd_en,
        input  full, almost_full, data_out, empty, almost_empty, count
    );
    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output full, almost_full, data_out, empty, almost_empty, count
    );
`endif
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with standard/FWFT read mode, programmable thresholds and flush.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module sync_fifo_flex #(
    parameter int DEPTH         = 16,
    parameter int WIDTH         = 8,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input logic           clk,
    input logic           reset,
    sync_fifo_flex_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             empty_w;
    logic             full_w;
    logic             rd;
    logic             wr;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign rd      = bus.rd_en && !empty_w;
    assign wr      = bus.wr_en && (!full_w || rd);

    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_full  = (count_q >= CNT_W'(AFULL_THRESH));
    assign bus.almost_empty = (count_q <= CNT_W'(AEMPTY_THRESH));
    assign bus.count        = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr) wr_ptr <= ptr_next(wr_ptr);
            if (rd) rd_ptr <= ptr_next(rd_ptr);
            case ({wr, rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; flush and reset only discard it via the pointers.
    always_ff @(posedge clk) begin
        if (!bus.flush && wr) mem[wr_ptr] <= bus.data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = mem[rd_ptr];
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)                   dout_q <= '0;
                else if (!bus.flush && rd)   dout_q <= mem[rd_ptr];
            end
            assign bus.data_out = dout_q;
        end
    endgenerate

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en && !wr)       overflow_q  <= 1'b1;
            if (bus.rd_en && empty_w)   underflow_q <= 1'b1;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed self-checking bench for sync_fifo_flex: standard/FWFT at DEPTH=16 and a DEPTH=5 wrap case.
module tb_sync_fifo_flex;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_flex_if #(.DEPTH(16), .WIDTH(8)) s_if ();
    sync_fifo_flex_if #(.DEPTH(16), .WIDTH(8)) f_if ();
    sync_fifo_flex_if #(.DEPTH(5),  .WIDTH(8)) d_if ();

    sync_fifo_flex #(.DEPTH(16), .WIDTH(8), .FWFT(0)) u_std (.clk(clk), .reset(reset), .bus(s_if));
    sync_fifo_flex #(.DEPTH(16), .WIDTH(8), .FWFT(1)) u_fw  (.clk(clk), .reset(reset), .bus(f_if));
    sync_fifo_flex #(.DEPTH(5),  .WIDTH(8), .FWFT(0)) u_d5  (.clk(clk), .reset(reset), .bus(d_if));

    typedef struct {
        logic       fl, we, re;
        logic [7:0] din;
        logic [4:0] cnt;
        logic       emp, ful, af, ae;
        logic [7:0] dout;
    } vec_t;

    vec_t vt[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic s_drv(input logic fl, input logic we, input logic re, input logic [7:0] din);
        s_if.flush = fl; s_if.wr_en = we; s_if.rd_en = re; s_if.data_in = din;
    endtask

    task automatic f_drv(input logic we, input logic re, input logic [7:0] din);
        f_if.flush = 1'b0; f_if.wr_en = we; f_if.rd_en = re; f_if.data_in = din;
    endtask

    task automatic d_drv(input logic we, input logic re, input logic [7:0] din);
        d_if.flush = 1'b0; d_if.wr_en = we; d_if.rd_en = re; d_if.data_in = din;
    endtask

    initial begin
        vec_t v;
        logic [4:0] c;

        // Fill 0x01..0x10, one rejected write, drain, one extra read, then empty wr+rd.
        for (int unsigned k = 0; k < 16; k++) begin
            c = 5'(k + 1);
            v = '{1'b0, 1'b1, 1'b0, 8'(k + 1), c, 1'b0, (c == 16), (c >= 14), (c <= 2), 8'h00};
            vt.push_back(v);
        end
        vt.push_back('{1'b0, 1'b1, 1'b0, 8'hEE, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
        for (int unsigned k = 0; k < 16; k++) begin
            c = 5'(15 - k);
            v = '{1'b0, 1'b0, 1'b1, 8'h00, c, (c == 0), 1'b0, (c >= 14), (c <= 2), 8'(k + 1)};
            vt.push_back(v);
        end
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10});
        vt.push_back('{1'b0, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10});
        vt.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C});

        s_drv(0, 0, 0, 8'h00); f_drv(0, 0, 8'h00); d_drv(0, 0, 8'h00);
        d_if.flush = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();

        chk("rst_count", 32'(s_if.count), 0);
        chk("rst_empty", 32'(s_if.empty), 1);
        chk("rst_full", 32'(s_if.full), 0);
        chk("rst_aempty", 32'(s_if.almost_empty), 1);
        chk("rst_afull", 32'(s_if.almost_full), 0);
        chk("rst_dout", 32'(s_if.data_out), 0);
        chk("rst_fw_empty", 32'(f_if.empty), 1);
        chk("rst_d5_count", 32'(d_if.count), 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("rst_ovf", 32'(s_if.overflow), 0);
        chk("rst_unf", 32'(s_if.underflow), 0);
`endif

        for (int unsigned i = 0; i < vt.size(); i++) begin
            s_drv(vt[i].fl, vt[i].we, vt[i].re, vt[i].din);
            cyc();
            chk($sformatf("vec%0d_count", i), 32'(s_if.count), 32'(vt[i].cnt));
            chk($sformatf("vec%0d_empty", i), 32'(s_if.empty), 32'(vt[i].emp));
            chk($sformatf("vec%0d_full", i), 32'(s_if.full), 32'(vt[i].ful));
            chk($sformatf("vec%0d_afull", i), 32'(s_if.almost_full), 32'(vt[i].af));
            chk($sformatf("vec%0d_aempty", i), 32'(s_if.almost_empty), 32'(vt[i].ae));
            chk($sformatf("vec%0d_dout", i), 32'(s_if.data_out), 32'(vt[i].dout));
`ifdef FIFO_ERR_FLAGS_EN
            if (i == 15) chk("ovf_before", 32'(s_if.overflow), 0);
            if (i == 16) chk("ovf_set", 32'(s_if.overflow), 1);
            if (i == 32) chk("unf_before", 32'(s_if.underflow), 0);
            if (i == 33) chk("unf_set", 32'(s_if.underflow), 1);
`endif
        end

        // Flush clears sticky flags and keeps data_out; then full with write+read.
        s_drv(1, 0, 0, 8'h00); cyc();
        chk("flush1_count", 32'(s_if.count), 0);
        chk("flush1_dout", 32'(s_if.data_out), 32'h3C);
`ifdef FIFO_ERR_FLAGS_EN
        chk("flush1_ovf", 32'(s_if.overflow), 0);
        chk("flush1_unf", 32'(s_if.underflow), 0);
`endif
        for (int unsigned k = 0; k < 16; k++) begin
            s_drv(0, 1, 0, 8'(k + 1)); cyc();
        end
        chk("fill_full", 32'(s_if.full), 1);
        s_drv(0, 1, 1, 8'h77); cyc();
        chk("fullrw_dout", 32'(s_if.data_out), 32'h01);
        chk("fullrw_count", 32'(s_if.count), 16);
        chk("fullrw_full", 32'(s_if.full), 1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("fullrw_ovf", 32'(s_if.overflow), 0);
`endif
        for (int unsigned k = 0; k < 16; k++) begin
            s_drv(0, 0, 1, 8'h00); cyc();
            chk($sformatf("drain%0d_dout", k), 32'(s_if.data_out), (k == 15) ? 32'h77 : 32'(k + 2));
        end
        chk("drain_empty", 32'(s_if.empty), 1);

        // Flush at count 7 with a concurrent write.
        for (int unsigned k = 0; k < 7; k++) begin
            s_drv(0, 1, 0, 8'(8'h40 + k)); cyc();
        end
        chk("pre_flush_count", 32'(s_if.count), 7);
        s_drv(1, 1, 0, 8'h99); cyc();
        chk("flush2_count", 32'(s_if.count), 0);
        chk("flush2_empty", 32'(s_if.empty), 1);
        chk("flush2_dout", 32'(s_if.data_out), 32'h77);
        s_drv(0, 1, 0, 8'h55); cyc();
        s_drv(0, 0, 1, 8'h00); cyc();
        chk("post_flush_dout", 32'(s_if.data_out), 32'h55);
        chk("post_flush_empty", 32'(s_if.empty), 1);
        s_drv(0, 0, 0, 8'h00);

        // FWFT: written word is visible right after its write edge.
        f_drv(1, 0, 8'hA5); cyc();
        chk("fw_a5_dout", 32'(f_if.data_out), 32'hA5);
        chk("fw_a5_empty", 32'(f_if.empty), 0);
        chk("fw_a5_count", 32'(f_if.count), 1);
        f_drv(0, 1, 8'h00); cyc();
        chk("fw_pop_empty", 32'(f_if.empty), 1);
        chk("fw_pop_count", 32'(f_if.count), 0);
        f_drv(1, 0, 8'hB1); cyc();
        f_drv(1, 0, 8'hB2); cyc();
        f_drv(1, 0, 8'hB3); cyc();
        chk("fw_b1_dout", 32'(f_if.data_out), 32'hB1);
        f_drv(0, 1, 8'h00); cyc();
        chk("fw_b2_dout", 32'(f_if.data_out), 32'hB2);
        f_drv(0, 1, 8'h00); cyc();
        chk("fw_b3_dout", 32'(f_if.data_out), 32'hB3);
        f_drv(1, 1, 8'hC4); cyc();
        chk("fw_c4_dout", 32'(f_if.data_out), 32'hC4);
        chk("fw_c4_count", 32'(f_if.count), 1);
        f_drv(0, 0, 8'h00);

        // DEPTH=5: pointer wrap with order preserved.
        for (int unsigned k = 1; k <= 5; k++) begin
            d_drv(1, 0, 8'(k)); cyc();
        end
        chk("d5_full", 32'(d_if.full), 1);
        chk("d5_afull", 32'(d_if.almost_full), 1);
        for (int unsigned k = 1; k <= 3; k++) begin
            d_drv(0, 1, 8'h00); cyc();
            chk($sformatf("d5_rd%0d", k), 32'(d_if.data_out), 32'(k));
        end
        chk("d5_count2", 32'(d_if.count), 2);
        for (int unsigned k = 6; k <= 8; k++) begin
            d_drv(1, 0, 8'(k)); cyc();
        end
        chk("d5_refull", 32'(d_if.full), 1);
        d_drv(1, 1, 8'h09); cyc();
        chk("d5_fullrw_dout", 32'(d_if.data_out), 4);
        chk("d5_fullrw_count", 32'(d_if.count), 5);
        for (int unsigned k = 5; k <= 9; k++) begin
            d_drv(0, 1, 8'h00); cyc();
            chk($sformatf("d5_wrap%0d", k), 32'(d_if.data_out), 32'(k));
        end
        chk("d5_empty", 32'(d_if.empty), 1);
        d_drv(0, 0, 8'h00);

        // Asynchronous reset mid-burst at count 9, checked between clock edges.
        for (int unsigned k = 0; k < 9; k++) begin
            s_drv(0, 1, 0, 8'(8'h60 + k)); cyc();
        end
        chk("burst_count", 32'(s_if.count), 9);
        #1 reset = 1'b1;
        #1;
        chk("arst_count", 32'(s_if.count), 0);
        chk("arst_empty", 32'(s_if.empty), 1);
        chk("arst_full", 32'(s_if.full), 0);
        chk("arst_aempty", 32'(s_if.almost_empty), 1);
        chk("arst_afull", 32'(s_if.almost_full), 0);
        chk("arst_dout", 32'(s_if.data_out), 0);
        chk("arst_d5_dout", 32'(d_if.data_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
